// File: rtl/text_overlay_renderer.sv
// Text-line overlay: N_CHARS-byte character buffer rendered as 8x16 glyphs over the background pixel.
// Optional build macro TEXT_BLINK_EN enables per-character blink (code bit7) driven by frame_start.
module text_overlay_renderer #(
    parameter int           N_CHARS      = 16,
    parameter int           ORIGIN_X     = 230,
    parameter int           ORIGIN_Y     = 80,
    parameter int           CHAR_PITCH   = 20,
    parameter logic [23:0]  FG_RGB       = 24'hFFFF00,
    parameter int           BLINK_FRAMES = 32,
    localparam int          IW           = $clog2(N_CHARS)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [9:0]      DrawX,
    input  logic [9:0]      DrawY,
    input  logic            pix_valid,
    input  logic            frame_start,
    input  logic [7:0]      bg_Red,
    input  logic [7:0]      bg_Green,
    input  logic [7:0]      bg_Blue,
    input  logic            text_enable,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [7:0]      wr_char,
    input  logic            clear,
    output logic            busy,
    output logic [10:0]     font_addr,
    input  logic [7:0]      font_data,
    output logic [7:0]      Red,
    output logic [7:0]      Green,
    output logic [7:0]      Blue,
    output logic            out_valid,
    output logic            text_hit
);

    // state  | meaning
    // IDLE   | buffer accepts writes and clear requests
    // CLEAR  | one cell per cycle is filled with a space, ptr walks 0..N_CHARS-1
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      char_q [N_CHARS];
    logic [7:0]      char_d [N_CHARS];

    logic            s1_valid_q, s1_valid_d;
    logic            s1_hit_q, s1_hit_d;
    logic [2:0]      s1_col_q, s1_col_d;
    logic [3:0]      s1_row_q, s1_row_d;
    logic [7:0]      s1_code_q, s1_code_d;
    logic            s1_en_q, s1_en_d;
    logic [23:0]     s1_bg_q, s1_bg_d;

    logic            out_valid_q, out_valid_d;
    logic            text_hit_q, text_hit_d;
    logic [23:0]     rgb_q, rgb_d;

    logic            visible;
    logic [10:0]     x_ext, y_ext;
    logic            row_in;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + IW'(1);
                if (ptr_q == IW'(N_CHARS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear has priority over a same-cycle write; writes are dropped while clearing.
    always_comb begin
        busy   = (state_q == ST_CLEAR);
        char_d = char_q;
        if (state_q == ST_CLEAR) begin
            char_d[ptr_q] = 8'h20;
        end else if (!clear && wr_en) begin
            for (int i = 0; i < N_CHARS; i++) begin
                if (wr_idx == IW'(i)) char_d[i] = wr_char;
            end
        end
    end

    // Stage 1: locate the character cell with an unrolled compare chain (11-bit, no wrap).
    always_comb begin
        x_ext      = {1'b0, DrawX};
        y_ext      = {1'b0, DrawY};
        row_in     = (y_ext >= 11'(ORIGIN_Y)) && (y_ext <= 11'(ORIGIN_Y + 15));
        s1_hit_d   = 1'b0;
        s1_col_d   = '0;
        s1_code_d  = '0;
        s1_row_d   = 4'(y_ext - 11'(ORIGIN_Y));
        s1_valid_d = pix_valid;
        s1_en_d    = text_enable;
        s1_bg_d    = {bg_Red, bg_Green, bg_Blue};
        for (int i = 0; i < N_CHARS; i++) begin
            if ((x_ext >= 11'(ORIGIN_X + i * CHAR_PITCH)) &&
                (x_ext <= 11'(ORIGIN_X + i * CHAR_PITCH + 7))) begin
                s1_hit_d  = pix_valid & row_in;
                s1_col_d  = 3'(x_ext - 11'(ORIGIN_X + i * CHAR_PITCH));
                s1_code_d = char_q[i];
            end
        end
    end

    assign font_addr = {s1_code_q[6:0], s1_row_q};

    always_comb begin
        text_hit_d  = s1_hit_q & s1_en_q & (s1_code_q[6:0] != 7'd0) &
                      font_data[3'd7 - s1_col_q] & visible;
        rgb_d       = text_hit_d ? FG_RGB : s1_bg_q;
        out_valid_d = s1_valid_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            char_q      <= '{default: 8'h20};
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s1_code_q   <= '0;
            s1_en_q     <= 1'b0;
            s1_bg_q     <= '0;
            out_valid_q <= 1'b0;
            text_hit_q  <= 1'b0;
            rgb_q       <= '0;
        end else begin
            char_q      <= char_d;
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            s1_code_q   <= s1_code_d;
            s1_en_q     <= s1_en_d;
            s1_bg_q     <= s1_bg_d;
            out_valid_q <= out_valid_d;
            text_hit_q  <= text_hit_d;
            rgb_q       <= rgb_d;
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_start) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign visible = ~(s1_code_q[7] & ~blink_on_q);
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_bits;
    assign unused_bits = ^{frame_start, s1_code_q[7], 32'(unused_blink_frames)};
    assign visible     = 1'b1;
`endif

    assign out_valid = out_valid_q;
    assign text_hit  = text_hit_q;
    assign {Red, Green, Blue} = rgb_q;

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Randomised bench for text_overlay_renderer against a cell/glyph reference model with a stand-in font ROM.
module tb_text_overlay_renderer;
    localparam int N   = 16;
    localparam int OX  = 230;
    localparam int OY  = 80;
    localparam int PIT = 20;
    localparam int BF  = 2;

    logic        Clk = 0;
    logic        Reset = 1;
    logic [9:0]  DrawX = 0, DrawY = 0;
    logic        pix_valid = 0, frame_start = 0;
    logic [7:0]  bg_Red = 0, bg_Green = 0, bg_Blue = 0;
    logic        text_enable = 0, wr_en = 0, clear = 0;
    logic [3:0]  wr_idx = 0;
    logic [7:0]  wr_char = 0;
    logic        busy, out_valid, text_hit;
    logic [10:0] font_addr;
    logic [7:0]  font_data, Red, Green, Blue;

    text_overlay_renderer #(.BLINK_FRAMES(BF)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .frame_start(frame_start), .bg_Red(bg_Red), .bg_Green(bg_Green), .bg_Blue(bg_Blue),
        .text_enable(text_enable), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .clear(clear), .busy(busy), .font_addr(font_addr), .font_data(font_data),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid), .text_hit(text_hit));

    always #5 Clk = ~Clk;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        logic [15:0] h;
        h = {5'b0, a} * 16'd40503;
        return h[15:8] ^ h[7:0];
    endfunction

    assign font_data = font_fn(font_addr);

    typedef struct packed {
        logic        v;
        logic        hit;
        logic [23:0] rgb;
    } exp_t;

    exp_t       e1, e2;
    logic [7:0] mbuf [N];
    int         clr_left = 0;
    int         frames = 0;
    int         n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Expected output for the pixel currently presented, from the model buffer and glyph ROM.
    function automatic exp_t model_entry();
        exp_t e;
        int   x, y, ox, c;
        logic [7:0] code, bits;
        logic [3:0] r4;
        logic vis;
        e.v   = pix_valid;
        e.hit = 1'b0;
        e.rgb = {bg_Red, bg_Green, bg_Blue};
        x = int'(DrawX);
        y = int'(DrawY);
        if (pix_valid && text_enable && y >= OY && y <= OY + 15) begin
            for (int i = 0; i < N; i++) begin
                ox = OX + i * PIT;
                if (x >= ox && x <= ox + 7) begin
                    code = mbuf[i];
                    r4   = 4'(y - OY);
                    c    = x - ox;
`ifdef TEXT_BLINK_EN
                    vis = !code[7] || (((frames / BF) % 2) == 0);
`else
                    vis = 1'b1;
`endif
                    bits = font_fn({code[6:0], r4});
                    if (code[6:0] != 7'd0 && vis && bits[7 - c]) begin
                        e.hit = 1'b1;
                        e.rgb = 24'hFFFF00;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic cyc();
        exp_t ne;
        ne = model_entry();
        @(posedge Clk);
        if (Reset) begin
            e1 = '0; e2 = '0; clr_left = 0; frames = 0;
            for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
        end else begin
            e2 = e1; e1 = ne;
            if (clr_left > 0) begin
                mbuf[N - clr_left] = 8'h20;
                clr_left--;
            end else if (clear) begin
                clr_left = N;
            end else if (wr_en) begin
                mbuf[wr_idx] = wr_char;
            end
            if (frame_start) frames++;
        end
        #1;
        chk("busy", busy, clr_left > 0);
        chk("out_valid", out_valid, e2.v);
        chk("rgb", {Red, Green, Blue}, e2.rgb);
        chk("text_hit", text_hit, e2.hit);
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = v;
        {bg_Red, bg_Green, bg_Blue} = 24'($urandom);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        text_enable = 1'b1;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                set_pix(x, y, $urandom_range(9, 0) != 0);
                cyc();
            end
    endtask

    task automatic write(input int idx, input logic [7:0] ch);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_char = ch;
        set_pix(OX, OY, 1'b1);
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        Reset = 1'b0;

        scan(225, 545, 79, 96);
        write(0, 8'h4C);
        scan(228, 240, 78, 97);
        write(1, 8'h45);
        scan(248, 272, 80, 96);

        for (int k = 0; k < 2500; k++) begin
            text_enable = $urandom_range(4, 0) != 0;
            if ($urandom_range(19, 0) == 0) begin
                wr_en = 1'b1; wr_idx = 4'($urandom); wr_char = 8'($urandom);
            end
            set_pix($urandom_range(545, 225), $urandom_range(97, 78), $urandom_range(7, 0) != 0);
            cyc();
            wr_en = 1'b0;
        end

        clear = 1'b1; wr_en = 1'b1; wr_idx = 4'd3; wr_char = 8'h5A;
        set_pix(OX, OY, 1'b1);
        cyc();
        clear = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            wr_en = $urandom_range(1, 0) != 0; wr_idx = 4'($urandom); wr_char = 8'h41;
            clear = (k == 4);
            set_pix($urandom_range(545, 225), $urandom_range(95, 80), 1'b1);
            cyc();
        end
        wr_en = 1'b0; clear = 1'b0;
        scan(228, 545, 85, 86);

        write(10, 8'h41);
        write(0, 8'h4D);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        scan(228, 440, 82, 84);

`ifdef TEXT_BLINK_EN
        write(0, 8'hCC);
        write(1, 8'h45);
        for (int f = 0; f < 6; f++) begin
            frame_start = 1'b1; pix_valid = 1'b0;
            cyc();
            frame_start = 1'b0;
            scan(230, 257, 80, 95);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
